// File: rtl/dma_copy.sv
// rtl/dma_copy.sv - single-channel memory-to-memory copy engine, one 64-bit beat at a time
module dma_copy #(
  parameter logic [3:0] ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst_bar,
  input  logic [79:0] cmd_msg,
  input  logic        cmd_val,
  output logic        cmd_rdy,
  output logic [1:0]  done_msg,
  output logic        done_val,
  input  logic        done_rdy,
  output logic [43:0] r_master0_ar_msg,
  output logic        r_master0_ar_val,
  input  logic        r_master0_ar_rdy,
  input  logic [70:0] r_master0_r_msg,
  input  logic        r_master0_r_val,
  output logic        r_master0_r_rdy,
  output logic [43:0] w_master0_aw_msg,
  output logic        w_master0_aw_val,
  input  logic        w_master0_aw_rdy,
  output logic [72:0] w_master0_w_msg,
  output logic        w_master0_w_val,
  input  logic        w_master0_w_rdy,
  input  logic [5:0]  w_master0_b_msg,
  input  logic        w_master0_b_val,
  output logic        w_master0_b_rdy
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic [15:0] rem_q, rem_d;
  logic [63:0] buf_q, buf_d;
  logic [1:0]  status_q, status_d;
  logic        aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic        cmd_rdy_q, cmd_rdy_d;

  // Returned IDs and read last are deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{r_master0_r_msg[70:67], r_master0_r_msg[0], w_master0_b_msg[5:2]};

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      buf_q     <= '0;
      status_q  <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      buf_q     <= buf_d;
      status_q  <= status_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_val && cmd_rdy_q) state_d = (cmd_msg[15:0] == 16'd0) ? DONE : RD_ADDR;
      RD_ADDR: if (r_master0_ar_rdy) state_d = RD_DATA;
      RD_DATA: if (r_master0_r_val) state_d = WR;
      WR:      if ((!aw_pend_q || w_master0_aw_rdy) && (!w_pend_q || w_master0_w_rdy)) state_d = WR_RESP;
      WR_RESP: if (w_master0_b_val) state_d = (rem_q == 16'd1) ? DONE : RD_ADDR;
      DONE:    if (done_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    buf_d     = buf_q;
    status_d  = status_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    // Registered so cmd_rdy stays low through reset and rises one edge after release.
    cmd_rdy_d = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (cmd_val && cmd_rdy_q) begin
          src_d    = cmd_msg[79:48];
          dst_d    = cmd_msg[47:16];
          rem_d    = cmd_msg[15:0];
          status_d = 2'b00;
        end
      end
      RD_DATA: begin
        if (r_master0_r_val) begin
          buf_d     = r_master0_r_msg[66:3];
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          if (r_master0_r_msg[2:1] > status_q) status_d = r_master0_r_msg[2:1];
        end
      end
      WR: begin
        if (w_master0_aw_rdy) aw_pend_d = 1'b0;
        if (w_master0_w_rdy)  w_pend_d  = 1'b0;
      end
      WR_RESP: begin
        if (w_master0_b_val) begin
          src_d = src_q + 32'd8;
          dst_d = dst_q + 32'd8;
          rem_d = rem_q - 16'd1;
          if (w_master0_b_msg[1:0] > status_q) status_d = w_master0_b_msg[1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_rdy          = cmd_rdy_q;
    done_val         = (state_q == DONE);
    done_msg         = status_q;
    r_master0_ar_val = (state_q == RD_ADDR);
    r_master0_ar_msg = {r_master0_ar_val ? ID : 4'd0, src_q[31:3], 3'b000, 8'd0};
    r_master0_r_rdy  = (state_q == RD_DATA);
    w_master0_aw_val = aw_pend_q;
    w_master0_aw_msg = {aw_pend_q ? ID : 4'd0, dst_q[31:3], 3'b000, 8'd0};
    w_master0_w_val  = w_pend_q;
    w_master0_w_msg  = {buf_q, w_pend_q ? 8'hFF : 8'h00, w_pend_q};
    w_master0_b_rdy  = (state_q == WR_RESP);
  end

endmodule

// File: doc/dma_copy.md
# dma_copy

Single-channel memory-to-memory copy engine acting as AXI-style master toward the `ram` slave. Accepts a copy command (source, destination, beat count) and moves data one 64-bit beat at a time: read beat from source, write it to destination, wait for write response, repeat. Reports completion and worst response code on a done channel. Sits directly upstream of `ram`; its master ports connect one-to-one to the `ram` slave ports.

## Interface
- `ID`, default 0: 4-bit transaction ID driven on every AR/AW beat.
- `clk` in 1: clock, rising edge.
- `rst_bar` in 1: asynchronous, active-low reset.
- `cmd_msg` in 80: {src_addr[79:48], dst_addr[47:16], beats[15:0]}.
- `cmd_val` in 1 / `cmd_rdy` out 1: command handshake.
- `done_msg` out 2: worst response (00 OKAY … 11 DECERR) seen during the command.
- `done_val` out 1 / `done_rdy` in 1: completion handshake.
- `r_master0_ar_msg` out 44: {id[43:40], addr[39:8], len[7:0]}. `_ar_val` out 1, `_ar_rdy` in 1.
- `r_master0_r_msg` in 71: {id[70:67], data[66:3], resp[2:1], last[0]}. `_r_val` in 1, `_r_rdy` out 1.
- `w_master0_aw_msg` out 44: same layout as AR. `_aw_val` out 1, `_aw_rdy` in 1.
- `w_master0_w_msg` out 73: {data[72:9], strb[8:1], last[0]}. `_w_val` out 1, `_w_rdy` in 1.
- `w_master0_b_msg` in 6: {id[5:2], resp[1:0]}. `_b_val` in 1, `_b_rdy` out 1.
- One clock; reset is asynchronous and active-low, on `rst_bar`.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE: `cmd_rdy`=1. On `cmd_val`: latch src, dst, beats; clear status to 00. If beats==0 go to DONE, else RD_ADDR.
- RD_ADDR: `ar_val`=1, addr=src_cur with bits[2:0] forced 0, len=0, id=ID. On `ar_rdy` -> RD_DATA.
- RD_DATA: `r_rdy`=1. On `r_val`: capture data into 64-bit buffer; status=max(status, resp) -> WR.
- WR: `aw_val` and `w_val` both asserted on entry; each dropped independently after its own handshake (AW and W may complete in either order or same cycle). aw addr=dst_cur[31:3]<<3, len=0; w strb=8'hFF, last=1, data=buffer. When both done -> WR_RESP.
- WR_RESP: `b_rdy`=1. On `b_val`: status=max(status, resp); src_cur+=8, dst_cur+=8 (mod 2^32, wraps silently); remaining-=1. remaining==0 -> DONE, else RD_ADDR.
- DONE: `done_val`=1, `done_msg`=status. On `done_rdy` -> IDLE.
- Non-OKAY responses do not abort; copy continues, status sticky at maximum.
- Returned r/b IDs and r last are not checked.
- Exactly one transaction outstanding at any time; never an AR while a write is open.

## Timing
- Reset: state IDLE; `cmd_rdy`=0 during reset, 1 first cycle after release; all `*_val`, `*_rdy` outputs 0; all msg outputs 0; status 00.
- All outputs registered/state-decoded; no combinational path from any input to any output.
- Zero-wait slave: 4 cycles per beat (RD_ADDR, RD_DATA, WR, WR_RESP); command of N beats: cmd accept edge to `done_val` = 4N+1 cycles; beats==0: `done_val` one cycle after accept.
- `*_val` held with stable msg until accepted; backpressure any length.
- Back-to-back commands: `cmd_rdy` high the cycle after done handshake.
- Reset mid-operation: immediate return to IDLE, outstanding transaction abandoned; slave must be reset together.

## Test plan
- Copy src=0x100, dst=0x200, beats=4 with zero-wait ram preloaded 0x100..0x11F -> four AR at 0x100,0x108,0x110,0x118, matching AW at 0x200..0x218, ram[0x200..0x21F] equals source, `done_msg`=00, done 17 cycles after accept.
- beats=0 -> no AR/AW/W, `done_val` next cycle, `done_msg`=00.
- Random stalls on ar_rdy/r_val/aw_rdy/w_rdy/b_val and done_rdy, beats=16 -> data correct, val/msg stable while stalled, never two transactions open.
- W accepted 3 cycles before AW, then AW before W on next beat -> single write per beat, proceeds only after both plus B.
- Slave returns SLVERR on beat 2 read, DECERR on beat 3 write, beats=5 -> all 5 beats executed, `done_msg`=11.
- src=0xFFFFFFF8, beats=2 -> second AR addr 0x00000000; assert rst_bar low during RD_DATA -> all val outputs 0 asynchronously, `cmd_rdy`=1 after release.
